// File: rtl/sound_ch1_sequencer.sv
// rtl/sound_ch1_sequencer.sv - channel 1 register file, trigger and frame/tone enable sequencer
module sound_ch1_sequencer #(
    parameter int PRESCALE = 8192,
    parameter int TONE_DIV = 32
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iPowerOn,
    input  logic       iWe,
    input  logic [2:0] iAddr,
    input  logic [7:0] iData,
    output logic [7:0] oReadData,
    output logic [7:0] oNR10,
    output logic [7:0] oNR11,
    output logic [7:0] oNR12,
    output logic [7:0] oNR13,
    output logic [7:0] oNR14,
    output logic       oTrigger,
    output logic       oLenTick,
    output logic       oSweepTick,
    output logic       oEnvTick,
    output logic       oToneTick,
    output logic [2:0] oStep
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [PW-1:0] prescaleCnt;
    logic [TW-1:0] toneCnt;
    logic          frameWrap;
    logic          toneWrap;
    logic          writeEn;

    assign frameWrap = (prescaleCnt == PW'(PRESCALE - 1));
    assign toneWrap  = (toneCnt == TW'(TONE_DIV - 1));
    assign writeEn   = iWe && iPowerOn && (iAddr <= 3'd4);

    // Power-off behaves exactly like reset, held for as long as it lasts.
    always_ff @(posedge iClock) begin
        if (iReset || !iPowerOn) begin
            oNR10       <= 8'h00;
            oNR11       <= 8'h00;
            oNR12       <= 8'h00;
            oNR13       <= 8'h00;
            oNR14       <= 8'h00;
            oTrigger    <= 1'b0;
            oLenTick    <= 1'b0;
            oSweepTick  <= 1'b0;
            oEnvTick    <= 1'b0;
            oToneTick   <= 1'b0;
            oStep       <= 3'd0;
            prescaleCnt <= '0;
            toneCnt     <= '0;
        end else begin
            if (writeEn) begin
                case (iAddr)
                    3'd0:    oNR10 <= iData;
                    3'd1:    oNR11 <= iData;
                    3'd2:    oNR12 <= iData;
                    3'd3:    oNR13 <= iData;
                    3'd4:    oNR14 <= {1'b0, iData[6:0]};
                    default: ;
                endcase
            end
            oTrigger <= writeEn && (iAddr == 3'd4) && iData[7];

            prescaleCnt <= frameWrap ? '0 : prescaleCnt + PW'(1);
            if (frameWrap) begin
                oStep <= oStep + 3'd1;
            end
            // Enables decode the step being left, not the one being entered.
            oLenTick   <= frameWrap && !oStep[0];
            oSweepTick <= frameWrap && (oStep[1:0] == 2'b10);
            oEnvTick   <= frameWrap && (oStep == 3'd7);

            toneCnt   <= toneWrap ? '0 : toneCnt + TW'(1);
            oToneTick <= toneWrap;
        end
    end

    always_comb begin
        oReadData = 8'hFF;
        case (iAddr)
            3'd0:    oReadData = {1'b1, oNR10[6:0]};
            3'd1:    oReadData = {oNR11[7:6], 6'h3F};
            3'd2:    oReadData = oNR12;
            3'd3:    oReadData = 8'hFF;
            3'd4:    oReadData = {1'b1, oNR14[6], 6'h3F};
            default: oReadData = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_sound_ch1_sequencer.sv
// tb/tb_sound_ch1_sequencer.sv - directed vector bench for sound_ch1_sequencer
module tb_sound_ch1_sequencer;

    localparam int P = 16;
    localparam int T = 4;

    logic       iClock = 1'b0;
    logic       iReset;
    logic       iPowerOn;
    logic       iWe;
    logic [2:0] iAddr;
    logic [7:0] iData;
    logic [7:0] oReadData, oNR10, oNR11, oNR12, oNR13, oNR14;
    logic       oTrigger, oLenTick, oSweepTick, oEnvTick, oToneTick;
    logic [2:0] oStep;

    sound_ch1_sequencer #(.PRESCALE(P), .TONE_DIV(T)) dut (
        .iClock(iClock), .iReset(iReset), .iPowerOn(iPowerOn), .iWe(iWe),
        .iAddr(iAddr), .iData(iData), .oReadData(oReadData),
        .oNR10(oNR10), .oNR11(oNR11), .oNR12(oNR12), .oNR13(oNR13), .oNR14(oNR14),
        .oTrigger(oTrigger), .oLenTick(oLenTick), .oSweepTick(oSweepTick),
        .oEnvTick(oEnvTick), .oToneTick(oToneTick), .oStep(oStep)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [2:0] rdAddr;
        logic [7:0] expRead;
        logic       expTrig;
        logic [7:0] e10, e11, e12, e13, e14;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   lenCnt, sweepCnt, envCnt;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ticks();
        return {oLenTick, oSweepTick, oEnvTick, oToneTick, oTrigger};
    endfunction

    initial begin
        iReset = 1'b1; iPowerOn = 1'b1; iWe = 1'b0; iAddr = 3'd0; iData = 8'h00;
        tick();
        // A trigger write during reset must be swallowed.
        iWe = 1'b1; iAddr = 3'd4; iData = 8'hFF;
        tick();
        iWe = 1'b0;
        check("reset ticks", 16'(ticks()), 16'h0);
        check("reset step", 16'(oStep), 16'h0);
        check("reset nr14", 16'(oNR14), 16'h0);
        check("reset nr10", 16'(oNR10), 16'h0);
        iReset = 1'b0;

        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd0, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd1, 8'h3F, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd3, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd4, 8'hBF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd5, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd6, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd7, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd1, 8'hC5, 3'd1, 8'hFF, 1'b0, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd4, 8'h47, 3'd4, 8'hFF, 1'b0, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h47});
        vecs.push_back('{1'b1, 3'd4, 8'h83, 3'd4, 8'hBF, 1'b1, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h03});
        vecs.push_back('{1'b1, 3'd4, 8'h80, 3'd4, 8'hBF, 1'b1, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 3'd4, 8'hBF, 1'b0, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd0, 8'hFF, 3'd0, 8'hFF, 1'b0, 8'hFF, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd0, 8'h12, 3'd0, 8'h92, 1'b0, 8'h12, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd0, 8'h34, 3'd0, 8'hB4, 1'b0, 8'h34, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd5, 8'hAA, 3'd5, 8'hFF, 1'b0, 8'h34, 8'hC5, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd2, 8'hF3, 3'd2, 8'hF3, 1'b0, 8'h34, 8'hC5, 8'hF3, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd3, 8'h5A, 3'd3, 8'hFF, 1'b0, 8'h34, 8'hC5, 8'hF3, 8'h5A, 8'h00});
        vecs.push_back('{1'b1, 3'd1, 8'h3F, 3'd1, 8'h3F, 1'b0, 8'h34, 8'h3F, 8'hF3, 8'h5A, 8'h00});

        foreach (vecs[i]) begin
            iWe = vecs[i].we; iAddr = vecs[i].addr; iData = vecs[i].data;
            tick();
            iWe = 1'b0; iAddr = vecs[i].rdAddr;
            #1;
            check($sformatf("vec%0d read", i), 16'(oReadData), 16'(vecs[i].expRead));
            check($sformatf("vec%0d trig", i), 16'(oTrigger), 16'(vecs[i].expTrig));
            check($sformatf("vec%0d nr", i), {oNR10, oNR11}, {vecs[i].e10, vecs[i].e11});
            check($sformatf("vec%0d nr12-14", i), {oNR12, oNR13}, {vecs[i].e12, vecs[i].e13});
            check($sformatf("vec%0d nr14", i), 16'(oNR14), 16'(vecs[i].e14));
        end

        // Frame sequencer and tone from a fresh reset.
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        lenCnt = 0; sweepCnt = 0; envCnt = 0;
        for (int k = 1; k <= 210; k++) begin
            logic [2:0] s;
            logic       wrap;
            logic [3:0] exp;
            if (k == 150) begin
                iWe = 1'b1; iAddr = 3'd2; iData = 8'h55;
            end
            tick();
            iWe = 1'b0;
            wrap = (k % P) == 0;
            s = 3'((k / P) - 1);
            exp = {wrap && !s[0], wrap && (s[1:0] == 2'b10), wrap && (s == 3'd7), (k % T) == 0};
            check($sformatf("frame k=%0d ticks", k), 16'({oLenTick, oSweepTick, oEnvTick, oToneTick}), 16'(exp));
            check($sformatf("frame k=%0d step", k), 16'(oStep), 16'((k / P) % 8));
            if (k <= 128) begin
                lenCnt += int'(oLenTick);
                sweepCnt += int'(oSweepTick);
                envCnt += int'(oEnvTick);
            end
        end
        check("len count", 16'(lenCnt), 16'd4);
        check("sweep count", 16'(sweepCnt), 16'd2);
        check("env count", 16'(envCnt), 16'd1);
        check("nr12 before off", 16'(oNR12), 16'h55);
        check("step before off", 16'(oStep), 16'd5);

        // Power-off mid step 5.
        iPowerOn = 1'b0;
        tick();
        iAddr = 3'd0;
        #1;
        check("off read nr10", 16'(oReadData), 16'h80);
        check("off step", 16'(oStep), 16'd0);
        check("off nr12", 16'(oNR12), 16'h00);
        iWe = 1'b1; iAddr = 3'd4; iData = 8'h80;
        tick();
        iWe = 1'b0;
        check("off trig", 16'(ticks()), 16'h0);
        check("off nr14", 16'(oNR14), 16'h00);
        iAddr = 3'd4;
        #1;
        check("off read nr14", 16'(oReadData), 16'hBF);
        tick();
        tick();
        check("off held ticks", 16'(ticks()), 16'h0);

        iPowerOn = 1'b1;
        for (int j = 1; j <= P + 1; j++) begin
            tick();
            check($sformatf("on j=%0d len", j), 16'(oLenTick), 16'(j == P));
            check($sformatf("on j=%0d tone", j), 16'(oToneTick), 16'((j % T) == 0));
        end
        check("on step", 16'(oStep), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sound_ch1_sequencer.md
# sound_ch1_sequencer

Control and sequencing block for sound channel 1. It owns the CPU-visible NR10–NR14 register file and converts a CPU write of NR14 bit 7 into a single-cycle trigger pulse. It also runs the 512 Hz frame sequencer that produces single-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) enables, plus the 131072 Hz tone enable. The block sits between the CPU I/O decoder and the channel 1 datapath, and drives it entirely with enables on the one system clock.

## Interface
Parameters:
- PRESCALE, 8192: iClock cycles per frame-sequencer step (4194304 / 512).
- TONE_DIV, 32: iClock cycles per tone enable (4194304 / 131072).

Ports:
- iClock  in  1  CPU clock, 4194304 Hz; only clock in the block.
- iReset  in  1  synchronous, active-high reset.
- iPowerOn  in  1  NR52 bit 7; 0 = sound off.
- iWe  in  1  CPU write strobe, one cycle per access.
- iAddr  in  3  register select, 0..4 = NR10..NR14; 5..7 unmapped.
- iData  in  8  write data.
- oReadData  out  8  masked read-back of the register at iAddr, combinational.
- oNR10, oNR11, oNR12, oNR13, oNR14  out  8 each  stored register values to the datapath; oNR14[7] is always 0.
- oTrigger  out  1  one-cycle restart pulse.
- oLenTick, oSweepTick, oEnvTick  out  1 each  one-cycle frame-sequencer enables.
- oToneTick  out  1  one-cycle enable, every TONE_DIV cycles.
- oStep  out  3  current frame-sequencer step.

## Operation
- Reset (iReset=1) wins over every other input:
  - All NRx registers 0; all ticks and oTrigger 0.
  - oStep=0; prescale counter and tone counter 0.
- Writes:
  - When iWe=1, iPowerOn=1 and iAddr<=4, the addressed register loads iData at the next clock edge.
  - NR14 stores {1'b0, iData[6:0]}.
  - Writes to addresses 5..7 are ignored.
- Trigger:
  - A write to NR14 with iData[7]=1 and iPowerOn=1 raises oTrigger for exactly one cycle.
  - That cycle is the cycle after the write, when oNR10..oNR14 already hold the new values.
  - Back-to-back trigger writes produce back-to-back pulses.
- Read masks (unused bits read 1):
  - NR10 = {1, reg[6:0]}.
  - NR11 = {reg[7:6], 6'h3F}.
  - NR12 = reg.
  - NR13 = 8'hFF.
  - NR14 = {1, reg[6], 6'h3F}.
  - Addresses 5..7 read 8'hFF.
- Power-off (iPowerOn=0), held every cycle:
  - Registers cleared and writes ignored.
  - Prescale counter, tone counter and oStep held at 0.
  - All ticks and oTrigger forced 0.
  - oReadData still applies the masks, so NR10 reads 8'h80.
- Frame sequencer:
  - The prescale counter counts 0..PRESCALE-1 and wraps.
  - On the wrap cycle, oStep increments mod 8.
  - In that same cycle the enables are decoded from the pre-increment step:
    - step 0: len
    - step 1: none
    - step 2: len + sweep
    - step 3: none
    - step 4: len
    - step 5: none
    - step 6: len + sweep
    - step 7: env
- Tone: the tone counter counts 0..TONE_DIV-1; oToneTick=1 on the wrap cycle. It runs independently of the frame sequencer.

## Timing
- All outputs except oReadData are registered.
- Write data is visible on oNRx one cycle after the iWe cycle.
- After reset release, or after iPowerOn rises, the frame-sequencer enables are registered from the prescale-counter wrap:
  - First oLenTick at cycle PRESCALE, with step 0 decoded.
  - oStep reads 1 at cycle PRESCALE+1.
  - Tick period is PRESCALE×2 for oLenTick, PRESCALE×4 for oSweepTick, PRESCALE×8 for oEnvTick.
- Step 7 wraps to step 0. The prescale counter does not stall on wrap.
- oTrigger and a frame tick may coincide. Both assert; the datapath handles precedence.
- iReset or iPowerOn falling mid-step discards the partial count. The next step boundary is a full PRESCALE later.
- A write to the same register in consecutive cycles: the last write wins, one value per cycle.

## Test plan
- Reset, then read back with PRESCALE=16, TONE_DIV=4:
  - Read all addresses: 80, 3F, 00, FF, BF; addresses 5..7 read FF.
  - oStep=0 and no ticks for the first 15 cycles.
- Write NR11=8'hC5, NR14=8'h47:
  - oNR11=C5; NR11 reads FF.
  - oNR14=47; NR14 reads FF.
  - No oTrigger.
- Write NR14=8'h83:
  - oNR14=03 next cycle with oTrigger=1 for one cycle.
  - NR14 reads BF.
- Frame sequencer, 128 cycles with PRESCALE=16:
  - Expect 4 oLenTick, 2 oSweepTick, 1 oEnvTick.
  - Ticks land at the cycles decoded for steps 0,2,4,6 / 2,6 / 7.
- Tone enable with TONE_DIV=4: exactly one oToneTick every 4 cycles, continuous across frame-step boundaries.
- Power-off mid-operation:
  - Drop iPowerOn at step 5: registers read masked zeros and oStep=0.
  - A trigger write issued while off produces no pulse.
  - Raise iPowerOn: first oLenTick 16 cycles later.
